// File: rtl/operand_sequencer.sv
// Sequences operand A/B register loads, starts the engine and waits for completion,
// raising a timeout error when a register ack or the engine completion never arrives.
module operand_sequencer #(
   parameter int unsigned N           = 4,
   parameter int unsigned ACK_TIMEOUT = 4,
   parameter int unsigned RUN_TIMEOUT = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         enter,
   input  logic [N-1:0] sw_data,
   input  logic         a_loaded,
   input  logic         b_loaded,
   input  logic         eng_done,
   output logic [N-1:0] reg_data,
   output logic         load_a,
   output logic         load_b,
   output logic         reg_clr,
   output logic         eng_start,
   output logic         busy,
   output logic         result_valid,
   output logic         timeout_err,
   output logic [3:0]   state_dbg
);

   localparam int unsigned MAX_TO = (ACK_TIMEOUT > RUN_TIMEOUT) ? ACK_TIMEOUT : RUN_TIMEOUT;
   localparam int unsigned CW     = $clog2(MAX_TO + 1);
   localparam logic [CW-1:0] ACK_LAST = CW'(ACK_TIMEOUT - 1);
   localparam logic [CW-1:0] RUN_LAST = CW'(RUN_TIMEOUT - 1);

   typedef enum logic [3:0] {
      IDLE   = 4'd0,
      LOAD_A = 4'd1,
      WAIT_A = 4'd2,
      GET_B  = 4'd3,
      LOAD_B = 4'd4,
      WAIT_B = 4'd5,
      START  = 4'd6,
      RUN    = 4'd7,
      FINISH = 4'd8,
      SHOW   = 4'd9,
      ERR    = 4'd10
   } state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [N-1:0]  reg_data_nx;
   logic          load_a_nx, load_b_nx, reg_clr_nx, eng_start_nx;
   logic          busy_nx, result_valid_nx, timeout_err_nx;

   // State, counter and every output are registered together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         cnt          <= '0;
         reg_data     <= '0;
         load_a       <= 1'b0;
         load_b       <= 1'b0;
         reg_clr      <= 1'b0;
         eng_start    <= 1'b0;
         busy         <= 1'b0;
         result_valid <= 1'b0;
         timeout_err  <= 1'b0;
         state_dbg    <= 4'd0;
      end else begin
         state        <= state_nx;
         cnt          <= cnt_nx;
         reg_data     <= reg_data_nx;
         load_a       <= load_a_nx;
         load_b       <= load_b_nx;
         reg_clr      <= reg_clr_nx;
         eng_start    <= eng_start_nx;
         busy         <= busy_nx;
         result_valid <= result_valid_nx;
         timeout_err  <= timeout_err_nx;
         state_dbg    <= state_nx;
      end
   end

   // Next state, counter, and outputs decoded from the state being entered.
   always_comb begin
      state_nx    = state;
      reg_data_nx = reg_data;
      cnt_nx      = '0;

      case (state)
         IDLE, SHOW: begin
            if (enter) begin
               state_nx    = LOAD_A;
               reg_data_nx = sw_data;
            end
         end
         LOAD_A: state_nx = WAIT_A;
         WAIT_A: begin
            if (a_loaded)             state_nx = GET_B;
            else if (cnt == ACK_LAST) state_nx = ERR;
         end
         GET_B: begin
            if (enter) begin
               state_nx    = LOAD_B;
               reg_data_nx = sw_data;
            end
         end
         LOAD_B: state_nx = WAIT_B;
         WAIT_B: begin
            if (b_loaded)             state_nx = START;
            else if (cnt == ACK_LAST) state_nx = ERR;
         end
         START:  state_nx = RUN;
         RUN: begin
            // A completion in the final allowed cycle still counts as success.
            if (eng_done)             state_nx = FINISH;
            else if (cnt == RUN_LAST) state_nx = ERR;
         end
         FINISH: state_nx = SHOW;
         ERR: begin
            if (enter) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase

      if ((state_nx == state) && (state inside {WAIT_A, WAIT_B, RUN}))
         cnt_nx = cnt + CW'(1);

      load_a_nx       = (state_nx == LOAD_A);
      load_b_nx       = (state_nx == LOAD_B);
      eng_start_nx    = (state_nx == START);
      reg_clr_nx      = (state_nx == FINISH) || ((state_nx == ERR) && (state != ERR));
      busy_nx         = !(state_nx inside {IDLE, GET_B, SHOW, ERR});
      result_valid_nx = (state_nx == SHOW);
      timeout_err_nx  = (state_nx == ERR);
   end

endmodule

// File: tb/tb_operand_sequencer.sv
// Bench for operand_sequencer: table of full operand/engine transactions checked
// through a load scoreboard, plus no-ack, engine-hang and mid-run reset sequences.
module tb_operand_sequencer;

   localparam int unsigned N = 4;
   localparam int unsigned ST_IDLE = 0, ST_LOAD_A = 1, ST_WAIT_A = 2, ST_GET_B = 3,
                           ST_LOAD_B = 4, ST_WAIT_B = 5, ST_START = 6, ST_RUN = 7,
                           ST_FINISH = 8, ST_SHOW = 9, ST_ERR = 10;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         enter = 1'b0;
   logic [N-1:0] sw_data = '0;
   logic         a_loaded = 1'b0;
   logic         b_loaded = 1'b0;
   logic         eng_done = 1'b0;
   logic [N-1:0] reg_data;
   logic         load_a, load_b, reg_clr, eng_start, busy, result_valid, timeout_err;
   logic [3:0]   state_dbg;

   operand_sequencer #(.N(N), .ACK_TIMEOUT(4), .RUN_TIMEOUT(64)) dut (
      .clk(clk), .rst(rst), .enter(enter), .sw_data(sw_data),
      .a_loaded(a_loaded), .b_loaded(b_loaded), .eng_done(eng_done),
      .reg_data(reg_data), .load_a(load_a), .load_b(load_b), .reg_clr(reg_clr),
      .eng_start(eng_start), .busy(busy), .result_valid(result_valid),
      .timeout_err(timeout_err), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit           is_b;
      logic [N-1:0] data;
   } sb_t;

   typedef struct {
      logic [N-1:0] a;
      logic [N-1:0] b;
      int           done_cnt;   // RUN counter value in the cycle eng_done is driven
      bit           spur;       // inject ignored enter/eng_done pulses
      bit           hang;       // never assert eng_done
      int unsigned  exp_final;
      int unsigned  exp_tmo;
   } vec_t;

   sb_t  exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   n_la = 0, n_lb = 0, n_st = 0, n_clr = 0;
   vec_t vecs[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock; samples #1 after the edge, counts pulses and drains the load scoreboard.
   task automatic step();
      sb_t e;
      @(posedge clk);
      #1;
      if (rst) begin
         chk("pulse_exclusive",
             32'(32'(load_a) + 32'(load_b) + 32'(eng_start) + 32'(reg_clr) <= 32'd1), 1);
         if (load_a)    n_la++;
         if (load_b)    n_lb++;
         if (eng_start) n_st++;
         if (reg_clr)   n_clr++;
         if (load_a || load_b) begin
            chk("load_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("load_kind_is_b", 32'(load_b), 32'(e.is_b));
               chk("load_reg_data", 32'(reg_data), 32'(e.data));
            end
         end
      end
   endtask

   task automatic push_exp(input bit is_b, input logic [N-1:0] d);
      sb_t e;
      e.is_b = is_b;
      e.data = d;
      exp_q.push_back(e);
   endtask

   // Operand A and B acceptance up to the first RUN cycle (cnt==0).
   task automatic front(input logic [N-1:0] a, input logic [N-1:0] b, input bit spur);
      sw_data = a; enter = 1'b1; push_exp(1'b0, a);
      step(); enter = 1'b0; sw_data = ~a;
      chk("enter_a_state", 32'(state_dbg), ST_LOAD_A);
      chk("enter_a_load_a", 32'(load_a), 1);
      chk("enter_a_valid_low", 32'(result_valid), 0);
      step();
      chk("wait_a_state", 32'(state_dbg), ST_WAIT_A);
      a_loaded = 1'b1; step(); a_loaded = 1'b0;
      chk("get_b_state", 32'(state_dbg), ST_GET_B);
      chk("get_b_busy", 32'(busy), 0);
      if (spur) begin
         eng_done = 1'b1; step(); eng_done = 1'b0;
         chk("spur_done_in_get_b", 32'(state_dbg), ST_GET_B);
      end
      sw_data = b; enter = 1'b1; push_exp(1'b1, b);
      step(); enter = 1'b0; sw_data = ~b;
      chk("load_b_state", 32'(state_dbg), ST_LOAD_B);
      chk("load_b_pulse", 32'(load_b), 1);
      step();
      chk("wait_b_state", 32'(state_dbg), ST_WAIT_B);
      b_loaded = 1'b1; step(); b_loaded = 1'b0;
      chk("start_state", 32'(state_dbg), ST_START);
      chk("start_pulse", 32'(eng_start), 1);
      step();
      chk("run_state", 32'(state_dbg), ST_RUN);
      chk("run_busy", 32'(busy), 1);
   endtask

   task automatic run_vec(input vec_t v);
      int st0, clr0, la0;
      st0 = n_st; clr0 = n_clr;
      front(v.a, v.b, v.spur);
      if (v.hang) begin
         repeat (63) step();
         chk("hang_still_run", 32'(state_dbg), ST_RUN);
         step();
         chk("final_state", 32'(state_dbg), v.exp_final);
         chk("hang_reg_clr", 32'(reg_clr), 1);
         chk("final_timeout", 32'(timeout_err), v.exp_tmo);
         step();
         chk("err_clr_once", 32'(reg_clr), 0);
         chk("err_hold", 32'(timeout_err), 1);
         la0 = n_la;
         enter = 1'b1; step(); enter = 1'b0;
         chk("err_exit_state", 32'(state_dbg), ST_IDLE);
         chk("err_exit_tmo", 32'(timeout_err), 0);
         step();
         chk("err_exit_no_load", 32'(n_la - la0), 0);
      end else begin
         for (int k = 0; k < v.done_cnt; k++) begin
            enter = (v.spur && k < 6 && (k % 2) == 0);
            step();
         end
         enter = 1'b0;
         chk("pre_done_state", 32'(state_dbg), ST_RUN);
         eng_done = 1'b1; step(); eng_done = 1'b0;
         chk("finish_state", 32'(state_dbg), ST_FINISH);
         chk("finish_reg_clr", 32'(reg_clr), 1);
         step();
         chk("final_state", 32'(state_dbg), v.exp_final);
         chk("final_timeout", 32'(timeout_err), v.exp_tmo);
         chk("show_valid", 32'(result_valid), 1);
         chk("show_busy", 32'(busy), 0);
         chk("show_reg_data", 32'(reg_data), 32'(v.b));
      end
      chk("one_eng_start", 32'(n_st - st0), 1);
      chk("one_reg_clr", 32'(n_clr - clr0), 1);
   endtask

   initial begin
      int lb0, st0, clr0;
      vecs[0] = '{a: 4'hA, b: 4'h3, done_cnt: 4,  spur: 1'b0, hang: 1'b0, exp_final: ST_SHOW, exp_tmo: 0};
      vecs[1] = '{a: 4'h5, b: 4'hC, done_cnt: 0,  spur: 1'b0, hang: 1'b0, exp_final: ST_SHOW, exp_tmo: 0};
      vecs[2] = '{a: 4'hF, b: 4'h0, done_cnt: 63, spur: 1'b0, hang: 1'b0, exp_final: ST_SHOW, exp_tmo: 0};
      vecs[3] = '{a: 4'h6, b: 4'h9, done_cnt: 8,  spur: 1'b1, hang: 1'b0, exp_final: ST_SHOW, exp_tmo: 0};
      vecs[4] = '{a: 4'h1, b: 4'h2, done_cnt: 0,  spur: 1'b0, hang: 1'b1, exp_final: ST_ERR,  exp_tmo: 1};

      #1 rst = 1'b0;
      #2;
      chk("reset_outputs",
          32'({reg_data, load_a, load_b, reg_clr, eng_start, busy, result_valid, timeout_err}), 0);
      chk("reset_state", 32'(state_dbg), ST_IDLE);
      step(); step();
      rst = 1'b1;
      step();
      chk("post_reset_state", 32'(state_dbg), ST_IDLE);

      foreach (vecs[i]) run_vec(vecs[i]);

      // Operand A register never acknowledges.
      lb0 = n_lb; st0 = n_st; clr0 = n_clr;
      sw_data = 4'h7; enter = 1'b1; push_exp(1'b0, 4'h7);
      step(); enter = 1'b0;
      step();
      chk("noack_wait_a", 32'(state_dbg), ST_WAIT_A);
      repeat (3) step();
      chk("noack_still_wait", 32'(state_dbg), ST_WAIT_A);
      step();
      chk("noack_err", 32'(state_dbg), ST_ERR);
      chk("noack_tmo", 32'(timeout_err), 1);
      repeat (3) step();
      chk("noack_no_load_b", 32'(n_lb - lb0), 0);
      chk("noack_no_start", 32'(n_st - st0), 0);
      chk("noack_one_clr", 32'(n_clr - clr0), 1);
      enter = 1'b1; step(); enter = 1'b0;
      chk("noack_exit_idle", 32'(state_dbg), ST_IDLE);

      // Asynchronous reset in the middle of RUN.
      clr0 = n_clr;
      front(4'hB, 4'h4, 1'b0);
      repeat (3) step();
      rst = 1'b0;
      #2;
      chk("midrun_reset_outputs",
          32'({reg_data, load_a, load_b, reg_clr, eng_start, busy, result_valid, timeout_err}), 0);
      chk("midrun_reset_state", 32'(state_dbg), ST_IDLE);
      step(); step();
      rst = 1'b1;
      step();
      chk("midrun_idle_after", 32'(state_dbg), ST_IDLE);
      chk("midrun_no_clr", 32'(n_clr - clr0), 0);
      chk("midrun_sb_empty", 32'(exp_q.size()), 0);
      run_vec(vecs[0]);

      chk("sb_drained", 32'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
